rx_deframer: RTL and testbench
==============================

# rx_deframer

Bit-serial HDLC-style receive deframer: the receive end of the synchronous serial link, clocked by `netclk`. It finds `0x7E` flags, deletes stuffed zeros and assembles octets LSB-first. It checks the CRC-16 (poly `0x1021`, init `0xFFFF`, complemented FCS sent MSB-first) and streams payload bytes to the upstream buffer with end-of-frame status. The FCS bytes are stripped; only payload reaches `data_out`.

## Interface

- No parameters.
- `netclk`  in  1  line clock; `rxdata` is sampled on posedge.
- `reset`  in  1  reset, asynchronous, active-high.
- `rxdata`  in  1  serial line data.
- `data_out`  out  8  payload byte, LSB = first bit received.
- `data_valid`  out  1  one-cycle strobe, `data_out` valid.
- `eop`  out  1  one-cycle strobe at closing flag.
- `frame_ok`  out  1  qualifies `eop`: CRC good, octet-aligned, length ≥ 3 octets.
- `crc_err`  out  1  qualifies `eop`: residue mismatch.
- `align_err`  out  1  qualifies `eop`: non-octet bit count, or fewer than 3 octets.
- `abort`  out  1  one-cycle strobe: 7 consecutive ones seen inside a frame.
- `in_frame`  out  1  level, high while in FRAME.

## Operation

- **Raw window:** an 8-bit shift register `win` holds the last 8 raw bits. A flag is `win` = 0,1,1,1,1,1,1,0 (oldest first). This also detects shared-zero flags.
- **Ones counter:** counts consecutive raw 1s, saturating at 7.
- **Zero deletion:** a 0 arriving after exactly five 1s is deleted, so no bit count, shift or CRC update occurs for it. A sixth 1 is kept.
- **States:**
  - HUNT (reset state): wait for a flag, then go to FRAME.
  - FRAME: on a flag, close the frame and stay in FRAME with counters cleared (back-to-back frames). When the ones counter reaches 7, pulse `abort` and go to HUNT.
  - HUNT ignores idle ones and produces no `abort`.
- **Frame start:** on entry to FRAME and after each flag, clear the bit counter (3 bits) and the octet counter (saturating at 3), and load the LFSR with `0xFFFF`.
- **Destuffed bits:** each destuffed bit shifts into the assembler MSB-first-in (`sh <= {bit, sh[7:1]}`). It also updates the LFSR: `fb = bit ^ lfsr[15]`, `lfsr <= {lfsr[14:0],0} ^ (fb ? 0x1021 : 0)`.
- **Octet complete** (bit counter wraps) and not coincident with a flag:
  - Push `sh` into a 2-deep delay line.
  - If the delay line was already full, emit its oldest byte on `data_out` with `data_valid`.
  - Snapshot the LFSR into `crc_snap`.
- **Closing flag:**
  - **Zero bits since the previous flag:** nothing is emitted.
  - **Otherwise:**
    - Pulse `eop`.
    - `align_err` = (bit counter ≠ 0 at flag completion) or (octets < 3).
    - `crc_err` = not `align_err` and `crc_snap` ≠ `0x1D0F`.
    - `frame_ok` = neither error.
    - Discard the delay line contents (the FCS) and clear the counters.
  - The status bits are valid only in the `eop` cycle and are 0 otherwise.
- **Payload forwarding:** each payload octet is emitted when the octet two positions later completes. All payload is therefore out before `eop`.
- **Discarding frames:** a misaligned frame may emit garbage bytes. The consumer discards the frame on `eop` with `frame_ok` = 0, or on `abort`.

## Timing

- **Output registers:** all outputs are registered and update on the posedge that samples the completing bit. `data_valid` therefore rises one cycle after the last bit of octet N+2 is on the line.
- **Pulse separation:** `data_valid` is at most 1 cycle per 8 bits. `eop` never coincides with `data_valid`.
- **Reset values:**
  - All outputs 0.
  - State HUNT.
  - `win` = `0xFF`.
  - Ones counter 0.
  - Delay line empty.
- **Reset mid-frame:** return to HUNT immediately. No `eop` or `abort` is issued.
- **Abort:** 7 ones inside a frame give `abort` on the seventh 1, with no `eop`. The delay line is flushed without emitting.
- **Shared zero:** the next flag may reuse the closing flag's final 0.
- **Line idle:** continuous ones after a flag abort any frame in progress. A further flag is required to resync.

## Test plan

- **Clean frame:** flag, payload `0x12 0x34 0x56`, correct FCS, flag → `data_out` 0x12, 0x34, 0x56 in order. Then one `eop` with `frame_ok`=1, `crc_err`=0, `align_err`=0.
- **Stuffing stress:** payload `0x7E 0x7D 0xFF 0x00 0x1F` with stuffed zeros → same 5 bytes out and `frame_ok`=1. Check every stuffed 0 was deleted and no false flag or abort fired.
- **CRC error:** clean frame with one payload bit flipped (stuffing recomputed) → all payload bytes emitted, `eop` with `crc_err`=1, `frame_ok`=0.
- **Alignment errors:**
  - Frame with 3 extra bits before the closing flag → `eop` with `align_err`=1.
  - Frame of only 2 octets → `eop` with `align_err`=1.
  - Two adjacent flags → no `eop`.
- **Abort:** 0x11, 0x22, then 8 ones mid-frame → `abort` on the seventh 1, `in_frame`=0, no `eop`. A later flag plus a clean frame is received with `frame_ok`=1.
- **Reset and back-to-back frames:**
  - Assert `reset` mid-payload → outputs 0, HUNT.
  - Two clean frames sharing one flag → two `eop` pulses, both with `frame_ok`=1.

Source files
------------

// File: rtl/rx_deframer.sv
// rx_deframer: HDLC-style bit-serial receive deframer (flag hunt, zero deletion, CRC-16 check).
// Ports: netclk line clock, reset async active-high, rxdata serial input;
//        data_out/data_valid payload bytes (LSB first on line), eop with frame_ok/crc_err/align_err
//        status, abort on 7 ones inside a frame, in_frame level while in FRAME.
module rx_deframer (
  input  logic       netclk,
  input  logic       reset,
  input  logic       rxdata,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       eop,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       align_err,
  output logic       abort,
  output logic       in_frame
);
  typedef enum logic {HUNT, FRAME} state_t;
  state_t      state;
  logic [7:0]  win, sh, d_old, d_new;
  logic [2:0]  ones, bit_cnt;
  logic [1:0]  oct_cnt, fill;
  logic [15:0] lfsr, crc_snap;
  logic [7:0]  win_nx, sh_nx;
  logic [15:0] lfsr_nx;
  logic        flag, stuffed, seventh, fb, bad_align, has_bits, crc_bad;
  always_comb begin
    win_nx    = {win[6:0], rxdata};
    flag      = win_nx == 8'h7E;
    stuffed   = !rxdata && ones == 3'd5;
    seventh   = rxdata && ones == 3'd6;
    sh_nx     = {rxdata, sh[7:1]};
    fb        = rxdata ^ lfsr[15];
    lfsr_nx   = {lfsr[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    // The flag's leading seven bits are counted as data, so an aligned frame
    // sits at bit 7 when the final flag zero arrives.
    bad_align = bit_cnt != 3'd7 || oct_cnt != 2'd3;
    has_bits  = oct_cnt != 2'd0;
    crc_bad   = crc_snap != 16'h1D0F;
  end
  always_ff @(posedge netclk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      win        <= 8'hFF;
      sh         <= '0;
      d_old      <= '0;
      d_new      <= '0;
      ones       <= '0;
      bit_cnt    <= '0;
      oct_cnt    <= '0;
      fill       <= '0;
      lfsr       <= 16'hFFFF;
      crc_snap   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      eop        <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      align_err  <= 1'b0;
      abort      <= 1'b0;
      in_frame   <= 1'b0;
    end else begin
      win        <= win_nx;
      ones       <= rxdata ? ones + 3'(ones != 3'd7) : 3'd0;
      data_valid <= 1'b0;
      eop        <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      align_err  <= 1'b0;
      abort      <= 1'b0;
      if (state == HUNT) begin
        if (flag) begin
          state    <= FRAME;
          in_frame <= 1'b1;
          bit_cnt  <= '0;
          oct_cnt  <= '0;
          fill     <= '0;
          lfsr     <= 16'hFFFF;
        end
      end else if (seventh) begin
        state    <= HUNT;
        in_frame <= 1'b0;
        abort    <= 1'b1;
        fill     <= '0;
      end else if (flag) begin
        // No completed octet since the last flag means only flag bits were seen.
        eop       <= has_bits;
        align_err <= has_bits && bad_align;
        crc_err   <= has_bits && !bad_align && crc_bad;
        frame_ok  <= has_bits && !bad_align && !crc_bad;
        bit_cnt   <= '0;
        oct_cnt   <= '0;
        fill      <= '0;
        lfsr      <= 16'hFFFF;
      end else if (!stuffed) begin
        sh      <= sh_nx;
        lfsr    <= lfsr_nx;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          // Two-octet delay keeps the FCS from ever reaching data_out.
          d_new      <= sh_nx;
          d_old      <= d_new;
          fill       <= fill + 2'(fill != 2'd2);
          data_valid <= fill == 2'd2;
          data_out   <= fill == 2'd2 ? d_old : data_out;
          crc_snap   <= lfsr_nx;
          oct_cnt    <= oct_cnt + 2'(oct_cnt != 2'd3);
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: table-driven and hand-sequenced checks of rx_deframer.
module tb_rx_deframer;
  logic       netclk = 1'b0;
  logic       reset = 1'b1;
  logic       rxdata = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, eop, frame_ok, crc_err, align_err, abort, in_frame;

  rx_deframer dut (
    .netclk(netclk), .reset(reset), .rxdata(rxdata), .data_out(data_out),
    .data_valid(data_valid), .eop(eop), .frame_ok(frame_ok), .crc_err(crc_err),
    .align_err(align_err), .abort(abort), .in_frame(in_frame)
  );

  always #5 netclk = ~netclk;

  typedef struct {
    logic [39:0] pl;
    int          len;
    int          extra;
    int          flip;
    logic [39:0] ex;
    int          nchk;
    int          exp_n;
    int          n_eop;
    logic        ok, ce, ae;
  } vec_t;

  int         total = 0, errs = 0;
  bit         raw[$];
  logic [7:0] rx[$];
  int         eop_n, ok_n, abort_n, inv_n;
  logic       last_ok, last_ce, last_ae;

  always @(negedge netclk) begin
    if (reset) begin
      rx.delete();
      eop_n = 0; ok_n = 0; abort_n = 0; inv_n = 0;
      last_ok = 0; last_ce = 0; last_ae = 0;
    end else begin
      if (data_valid) rx.push_back(data_out);
      if (eop) begin
        eop_n++;
        ok_n += int'(frame_ok);
        last_ok = frame_ok; last_ce = crc_err; last_ae = align_err;
      end
      if (abort) abort_n++;
      if (!eop && (frame_ok || crc_err || align_err)) inv_n++;
      if (eop && data_valid) inv_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    rxdata = b;
    @(posedge netclk);
    #1;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxdata = 1'b1;
    @(posedge netclk);
    @(posedge netclk);
    #1 reset = 1'b0;
  endtask

  task automatic add_bytes(input logic [39:0] pl, input int len);
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++) raw.push_back(pl[8*i+b]);
  endtask

  task automatic add_fcs();
    logic [15:0] crc, fcs;
    bit f;
    crc = 16'hFFFF;
    foreach (raw[i]) begin
      f = raw[i] ^ crc[15];
      crc = {crc[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    fcs = ~crc;
    for (int b = 15; b >= 0; b--) raw.push_back(fcs[b]);
  endtask

  task automatic build(input logic [39:0] pl, input int len, input int extra, input int flip);
    raw.delete();
    add_bytes(pl, len);
    add_fcs();
    for (int i = 0; i < extra; i++) raw.push_back(1'b0);
    if (flip >= 0) raw[flip] = ~raw[flip];
  endtask

  task automatic send_raw();
    int o;
    o = 0;
    foreach (raw[i]) begin
      send_bit(raw[i]);
      o = raw[i] ? o + 1 : 0;
      if (o == 5) begin
        send_bit(1'b0);
        o = 0;
      end
    end
  endtask

  vec_t tv[5];

  initial begin
    tv[0] = '{pl:40'h563412, len:3, extra:0, flip:-1, ex:40'h563412, nchk:3, exp_n:3, n_eop:1, ok:1, ce:0, ae:0};
    tv[1] = '{pl:40'h1F00FF7D7E, len:5, extra:0, flip:-1, ex:40'h1F00FF7D7E, nchk:5, exp_n:5, n_eop:1, ok:1, ce:0, ae:0};
    tv[2] = '{pl:40'h563412, len:3, extra:0, flip:3, ex:40'h56341A, nchk:3, exp_n:3, n_eop:1, ok:0, ce:1, ae:0};
    tv[3] = '{pl:40'h563412, len:3, extra:3, flip:-1, ex:40'h563412, nchk:3, exp_n:4, n_eop:1, ok:0, ce:0, ae:1};
    tv[4] = '{pl:40'h0, len:0, extra:0, flip:-1, ex:40'h0, nchk:0, exp_n:0, n_eop:1, ok:0, ce:0, ae:1};

    do_reset();
    chk("reset outputs", {data_out, data_valid, eop, frame_ok, crc_err, align_err, abort, in_frame}, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      send_ones(10);
      send_flag();
      build(tv[i].pl, tv[i].len, tv[i].extra, tv[i].flip);
      send_raw();
      send_flag();
      send_bit(1'b0);
      send_bit(1'b0);
      chk($sformatf("v%0d byte count", i), rx.size(), tv[i].exp_n);
      for (int j = 0; j < tv[i].nchk; j++)
        chk($sformatf("v%0d byte %0d", i, j), j < rx.size() ? {24'h0, rx[j]} : 32'h100, {24'h0, tv[i].ex[8*j+:8]});
      chk($sformatf("v%0d eop count", i), eop_n, tv[i].n_eop);
      chk($sformatf("v%0d frame_ok", i), last_ok, tv[i].ok);
      chk($sformatf("v%0d crc_err", i), last_ce, tv[i].ce);
      chk($sformatf("v%0d align_err", i), last_ae, tv[i].ae);
      chk($sformatf("v%0d abort count", i), abort_n, 0);
      chk($sformatf("v%0d status pulses", i), inv_n, 0);
    end

    do_reset();
    send_ones(10);
    send_flag();
    send_flag();
    send_flag();
    send_ones(6);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("adjacent flags eop", eop_n, 0);
    chk("adjacent flags in_frame", in_frame, 1);
    chk("adjacent flags abort", abort_n, 0);

    do_reset();
    send_ones(10);
    send_flag();
    raw.delete();
    add_bytes(40'h2211, 2);
    send_raw();
    send_ones(6);
    chk("abort before 7th one", abort, 0);
    send_bit(1'b1);
    chk("abort on 7th one", abort, 1);
    chk("abort in_frame", in_frame, 0);
    send_bit(1'b1);
    chk("abort single pulse", abort, 0);
    send_flag();
    build(40'h563412, 3, 0, -1);
    send_raw();
    send_flag();
    send_bit(1'b0);
    send_bit(1'b0);
    chk("abort count", abort_n, 1);
    chk("after abort eop count", eop_n, 1);
    chk("after abort frame_ok", last_ok, 1);
    chk("after abort byte count", rx.size(), 3);
    chk("after abort first byte", rx.size() > 0 ? {24'h0, rx[0]} : 32'h100, 32'h12);

    do_reset();
    send_ones(4);
    send_flag();
    build(40'h563412, 3, 0, -1);
    for (int i = 0; i < 12; i++) send_bit(raw[i]);
    chk("pre-reset in_frame", in_frame, 1);
    reset = 1'b1;
    #2;
    chk("mid reset outputs", {data_out, data_valid, eop, frame_ok, crc_err, align_err, abort, in_frame}, 0);
    @(posedge netclk);
    #1 reset = 1'b0;
    send_ones(10);
    send_flag();
    send_bit(1'b0);
    chk("post reset eop", eop_n, 0);
    chk("post reset abort", abort_n, 0);
    chk("post reset in_frame", in_frame, 1);

    do_reset();
    send_ones(10);
    send_flag();
    build(40'h563412, 3, 0, -1);
    send_raw();
    send_flag();
    send_ones(6);
    send_bit(1'b0);
    build(40'hEFCDAB, 3, 0, -1);
    send_raw();
    send_flag();
    send_bit(1'b0);
    send_bit(1'b0);
    chk("b2b eop count", eop_n, 2);
    chk("b2b ok count", ok_n, 2);
    chk("b2b byte count", rx.size(), 6);
    chk("b2b byte 3", rx.size() > 3 ? {24'h0, rx[3]} : 32'h100, 32'hAB);
    chk("b2b byte 5", rx.size() > 5 ? {24'h0, rx[5]} : 32'h100, 32'hEF);
    chk("b2b status pulses", inv_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", total, errs);
    $finish;
  end
endmodule
